// File: rtl/study_trainer.sv
// Guided-practice engine: walks a song ROM step by step, lights the goal key,
// optionally asks the sound player for a demo, then judges the player's hits.
module study_trainer #(
  parameter int NOTE_BITS      = 3,
  parameter int OCTAVE_BITS    = 3,
  parameter int LENGTH_BITS    = 3,
  parameter int NOTE_KEYS      = 7,
  parameter int STEP_BITS      = 6,
  parameter int SCORE_BITS     = 8,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   strict,
  input  logic                   demo_en,
  input  logic [STEP_BITS:0]     song_len,
  output logic [STEP_BITS-1:0]   step_addr,
  input  logic [OCTAVE_BITS-1:0] rom_octave,
  input  logic [NOTE_BITS-1:0]   rom_note,
  input  logic [LENGTH_BITS-1:0] rom_length,
  input  logic                   hit_valid,
  input  logic [OCTAVE_BITS-1:0] hit_octave,
  input  logic [NOTE_BITS-1:0]   hit_note,
  input  logic [LENGTH_BITS-1:0] hit_length,
  output logic                   play_req,
  input  logic                   sound_done,
  output logic [OCTAVE_BITS-1:0] goal_octave,
  output logic [NOTE_BITS-1:0]   goal_note,
  output logic [LENGTH_BITS-1:0] goal_length,
  output logic [NOTE_KEYS-1:0]   note_led,
  output logic                   correct,
  output logic                   wrong,
  output logic                   busy,
  output logic                   done,
  output logic [SCORE_BITS-1:0]  score,
  output logic [SCORE_BITS-1:0]  misses
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_DEMO     = 3'd3;
  localparam logic [2:0] S_WAIT_HIT = 3'd4;
  localparam logic [2:0] S_JUDGE    = 3'd5;
  localparam logic [2:0] S_ADVANCE  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam int TIMER_BITS = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RETRY_BITS = $clog2(MAX_RETRY) + 1;
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_BITS-1:0] RETRY_LAST = RETRY_BITS'(MAX_RETRY - 1);

  function automatic logic [SCORE_BITS-1:0] sat_add(input logic [SCORE_BITS-1:0] a,
                                                    input logic [1:0] inc);
    logic [SCORE_BITS:0] sum;
    sum = {1'b0, a} + (SCORE_BITS+1)'(inc);
    if (sum[SCORE_BITS]) begin
      sat_add = {SCORE_BITS{1'b1}};
    end else begin
      sat_add = sum[SCORE_BITS-1:0];
    end
  endfunction

  function automatic logic is_match(input logic [OCTAVE_BITS-1:0] ho, input logic [NOTE_BITS-1:0] hn,
                                    input logic [LENGTH_BITS-1:0] hl, input logic [OCTAVE_BITS-1:0] go,
                                    input logic [NOTE_BITS-1:0] gn, input logic [LENGTH_BITS-1:0] gl,
                                    input logic strict_mode);
    is_match = (ho == go) && (hn == gn) && (!strict_mode || (hl == gl));
  endfunction

  function automatic logic [NOTE_KEYS-1:0] key_led(input logic [NOTE_BITS-1:0] n);
    for (int i = 0; i < NOTE_KEYS; i++) begin
      key_led[i] = (int'(n) == i + 1);
    end
  endfunction

  logic [2:0]             state_q, state_d;
  logic [STEP_BITS-1:0]   step_q, step_d;
  logic [SCORE_BITS-1:0]  score_q, score_d, misses_q, misses_d;
  logic [RETRY_BITS-1:0]  retry_q, retry_d;
  logic [TIMER_BITS-1:0]  timer_q, timer_d;
  logic                   strict_q, strict_d, demo_q, demo_d, match_q, match_d;
  logic [STEP_BITS:0]     len_q, len_d;
  logic [OCTAVE_BITS-1:0] goal_octave_q, goal_octave_d;
  logic [NOTE_BITS-1:0]   goal_note_q, goal_note_d;
  logic [LENGTH_BITS-1:0] goal_length_q, goal_length_d;
  logic [STEP_BITS-1:0]   step_addr_q, step_addr_d;
  logic [NOTE_KEYS-1:0]   note_led_q, note_led_d;
  logic                   correct_q, correct_d, wrong_q, wrong_d, play_req_q, play_req_d;
  logic                   busy_q, busy_d, done_q, done_d;

  // Next-state, counters and registered outputs; the verdict is formed as the hit
  // is accepted so correct/wrong are visible during the judge cycle itself.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    score_d       = score_q;
    misses_d      = misses_q;
    retry_d       = retry_q;
    timer_d       = timer_q;
    strict_d      = strict_q;
    demo_d        = demo_q;
    len_d         = len_q;
    match_d       = match_q;
    goal_octave_d = goal_octave_q;
    goal_note_d   = goal_note_q;
    goal_length_d = goal_length_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            strict_d = strict;
            demo_d   = demo_en;
            len_d    = song_len;
            step_d   = '0;
            score_d  = '0;
            misses_d = '0;
            retry_d  = '0;
            state_d  = (song_len == '0) ? S_DONE : S_FETCH;
          end else begin
            state_d = state_q;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          goal_octave_d = rom_octave;
          goal_note_d   = rom_note;
          goal_length_d = rom_length;
          if (rom_note == '0) begin
            state_d = S_ADVANCE;
          end else if (demo_q) begin
            state_d = S_DEMO;
          end else begin
            timer_d = '0;
            state_d = S_WAIT_HIT;
          end
        end
        S_DEMO: begin
          if (sound_done) begin
            timer_d = '0;
            state_d = S_WAIT_HIT;
          end else begin
            state_d = S_DEMO;
          end
        end
        S_WAIT_HIT: begin
          timer_d = timer_q + TIMER_BITS'(1);
          if (hit_valid) begin
            match_d = is_match(hit_octave, hit_note, hit_length,
                               goal_octave_q, goal_note_q, goal_length_q, strict_q);
            state_d = S_JUDGE;
          end else if (timer_q == TIMER_LAST) begin
            match_d = 1'b0;
            state_d = S_JUDGE;
          end else begin
            state_d = S_WAIT_HIT;
          end
        end
        S_JUDGE: begin
          if (match_q) begin
            score_d = sat_add(score_q, (retry_q == '0) ? 2'd2 : 2'd1);
            state_d = S_ADVANCE;
          end else if (retry_q == RETRY_LAST) begin
            misses_d = sat_add(misses_q, 2'd1);
            state_d  = S_ADVANCE;
          end else begin
            retry_d = retry_q + RETRY_BITS'(1);
            if (demo_q) begin
              state_d = S_DEMO;
            end else begin
              timer_d = '0;
              state_d = S_WAIT_HIT;
            end
          end
        end
        S_ADVANCE: begin
          retry_d = '0;
          if ({1'b0, step_q} == len_q - (STEP_BITS+1)'(1)) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + STEP_BITS'(1);
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    step_addr_d = step_d;
    correct_d   = (state_d == S_JUDGE) && match_d;
    wrong_d     = (state_d == S_JUDGE) && !match_d;
    play_req_d  = (state_d == S_DEMO) && (state_q != S_DEMO);
    note_led_d  = (state_d == S_WAIT_HIT) ? key_led(goal_note_d) : '0;
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      score_q       <= '0;
      misses_q      <= '0;
      retry_q       <= '0;
      timer_q       <= '0;
      strict_q      <= 1'b0;
      demo_q        <= 1'b0;
      len_q         <= '0;
      match_q       <= 1'b0;
      goal_octave_q <= '0;
      goal_note_q   <= '0;
      goal_length_q <= '0;
      step_addr_q   <= '0;
      note_led_q    <= '0;
      correct_q     <= 1'b0;
      wrong_q       <= 1'b0;
      play_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      score_q       <= score_d;
      misses_q      <= misses_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      strict_q      <= strict_d;
      demo_q        <= demo_d;
      len_q         <= len_d;
      match_q       <= match_d;
      goal_octave_q <= goal_octave_d;
      goal_note_q   <= goal_note_d;
      goal_length_q <= goal_length_d;
      step_addr_q   <= step_addr_d;
      note_led_q    <= note_led_d;
      correct_q     <= correct_d;
      wrong_q       <= wrong_d;
      play_req_q    <= play_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign step_addr   = step_addr_q;
  assign goal_octave = goal_octave_q;
  assign goal_note   = goal_note_q;
  assign goal_length = goal_length_q;
  assign note_led    = note_led_q;
  assign correct     = correct_q;
  assign wrong       = wrong_q;
  assign play_req    = play_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign score       = score_q;
  assign misses      = misses_q;

endmodule

// File: tb/tb_study_trainer.sv
// Bench for study_trainer: a session/step/attempt-level model predicts every output
// each cycle while directed and random songs, hits, demos and timeouts are played.
module tb_study_trainer;
  localparam int TO   = 16;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic rst, start, abort, strict, demo_en, hit_valid, sound_done;
  logic [6:0] song_len;
  logic [5:0] step_addr, s_step_addr;
  logic [2:0] rom_octave, rom_note, rom_length, hit_octave, hit_note, hit_length;
  logic [2:0] goal_octave, goal_note, goal_length, s_goal_octave, s_goal_note, s_goal_length;
  logic       play_req, correct, wrong, busy, done;
  logic       s_play_req, s_correct, s_wrong, s_busy, s_done;
  logic [6:0] note_led, s_note_led;
  logic [7:0] score, misses;
  logic [1:0] s_score, s_misses;

  logic [2:0] song_o [64];
  logic [2:0] song_n [64];
  logic [2:0] song_l [64];

  int  n_checks = 0, n_errors = 0;
  bit  chk_en = 1'b0;
  int  exp_busy, exp_done, exp_led, exp_correct, exp_wrong, exp_play;
  int  exp_go, exp_gn, exp_gl, exp_addr;
  int  m_score, m_score_s, m_miss, m_miss_s;
  int  cnt_correct = 0, cnt_wrong = 0, cnt_play = 0, cnt_led = 0;
  int  plan[$];
  int  led_log[$];

  always #5 clk = ~clk;

  study_trainer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .strict(strict), .demo_en(demo_en),
    .song_len(song_len), .step_addr(step_addr), .rom_octave(rom_octave), .rom_note(rom_note),
    .rom_length(rom_length), .hit_valid(hit_valid), .hit_octave(hit_octave), .hit_note(hit_note),
    .hit_length(hit_length), .play_req(play_req), .sound_done(sound_done),
    .goal_octave(goal_octave), .goal_note(goal_note), .goal_length(goal_length),
    .note_led(note_led), .correct(correct), .wrong(wrong), .busy(busy), .done(done),
    .score(score), .misses(misses));

  study_trainer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR), .SCORE_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .strict(strict), .demo_en(demo_en),
    .song_len(song_len), .step_addr(s_step_addr), .rom_octave(rom_octave), .rom_note(rom_note),
    .rom_length(rom_length), .hit_valid(hit_valid), .hit_octave(hit_octave), .hit_note(hit_note),
    .hit_length(hit_length), .play_req(s_play_req), .sound_done(sound_done),
    .goal_octave(s_goal_octave), .goal_note(s_goal_note), .goal_length(s_goal_length),
    .note_led(s_note_led), .correct(s_correct), .wrong(s_wrong), .busy(s_busy), .done(s_done),
    .score(s_score), .misses(s_misses));

  // Song ROM with one cycle of read latency.
  always @(posedge clk) begin
    rom_octave <= song_o[step_addr];
    rom_note   <= song_n[step_addr];
    rom_length <= song_l[step_addr];
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, exp_busy);            chk("done", done, exp_done);
      chk("note_led", note_led, exp_led);     chk("correct", correct, exp_correct);
      chk("wrong", wrong, exp_wrong);         chk("play_req", play_req, exp_play);
      chk("goal_octave", goal_octave, exp_go); chk("goal_note", goal_note, exp_gn);
      chk("goal_length", goal_length, exp_gl); chk("step_addr", step_addr, exp_addr);
      chk("score", score, m_score);           chk("misses", misses, m_miss);
      chk("s_busy", s_busy, exp_busy);        chk("s_done", s_done, exp_done);
      chk("s_note_led", s_note_led, exp_led); chk("s_correct", s_correct, exp_correct);
      chk("s_wrong", s_wrong, exp_wrong);     chk("s_play_req", s_play_req, exp_play);
      chk("s_goal", {s_goal_octave, s_goal_note, s_goal_length}, exp_go * 64 + exp_gn * 8 + exp_gl);
      chk("s_step_addr", s_step_addr, exp_addr);
      chk("s_score", s_score, m_score_s);     chk("s_misses", s_misses, m_miss_s);
      if (correct) cnt_correct++;
      if (wrong) cnt_wrong++;
      if (play_req) cnt_play++;
      if (note_led != 7'd0) cnt_led++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int next_kind();
    int r;
    if (plan.size() > 0) return plan.pop_front();
    r = $urandom_range(0, 9);
    if (r < 5) return 0;
    else if (r < 7) return 1;
    else if (r == 7) return 2;
    else if (r == 8) return 3;
    else return 4;
  endfunction

  task automatic reset_exp();
    exp_busy = 0; exp_done = 0; exp_led = 0; exp_correct = 0; exp_wrong = 0; exp_play = 0;
    exp_go = 0; exp_gn = 0; exp_gl = 0; exp_addr = 0;
    m_score = 0; m_score_s = 0; m_miss = 0; m_miss_s = 0;
  endtask

  task automatic set_step(input int i, input int o, input int n, input int l);
    song_o[i] = 3'(o); song_n[i] = 3'(n); song_l[i] = 3'(l);
  endtask

  // Attempt kinds: 0 correct, 1 wrong octave/note, 2 length differs, 3 timeout, 4 hit on last timer cycle.
  // ctl_kind: 0 none, 1 abort, 2 rst -- applied in the first WAIT_HIT cycle of step ctl_step.
  task automatic run_session(input int len, input bit st, input bit de, input int ctl_step, input int ctl_kind);
    int retry, kind, k, d;
    bit fin, hv, mt;
    logic [2:0] ho, hn, hl, go, gn, gl;
    start = 1'b1; strict = st; demo_en = de; song_len = 7'(len);
    tick();
    start = 1'b0; strict = 1'($urandom_range(0, 1)); demo_en = 1'($urandom_range(0, 1));
    song_len = 7'($urandom_range(0, 127));
    m_score = 0; m_score_s = 0; m_miss = 0; m_miss_s = 0; exp_addr = 0;
    if (len == 0) begin
      exp_done = 1; exp_busy = 0;
      return;
    end
    exp_busy = 1; exp_done = 0;
    for (int s = 0; s < len; s++) begin
      exp_addr = s;
      tick();
      tick();
      go = song_o[s]; gn = song_n[s]; gl = song_l[s];
      exp_go = go; exp_gn = gn; exp_gl = gl;
      if (gn != 3'd0) begin
        retry = 0; fin = 1'b0;
        while (!fin) begin
          if (de) begin
            exp_play = 1;
            d = $urandom_range(0, 3);
            for (int c = 0; c <= d; c++) begin
              sound_done = (c == d);
              hit_valid  = 1'($urandom_range(0, 1));
              if ($urandom_range(0, 1) == 1) {hit_octave, hit_note, hit_length} = {go, gn, gl};
              else {hit_octave, hit_note, hit_length} = 9'($urandom_range(0, 511));
              tick();
              exp_play = 0;
            end
            sound_done = 1'b0; hit_valid = 1'b0;
          end
          kind = next_kind();
          if (kind == 3) k = TO;
          else if (kind == 4) k = TO - 1;
          else k = $urandom_range(0, 5);
          ho = go; hn = gn; hl = gl;
          if (kind == 1) begin
            if ($urandom_range(0, 1) == 1) hn = 3'((int'(gn) % 7) + 1);
            else ho = go + 3'd1;
          end
          if (kind == 2) hl = gl ^ 3'($urandom_range(1, 7));
          mt = (kind != 3) && (ho == go) && (hn == gn) && (!st || (hl == gl));
          exp_led = 1 << (int'(gn) - 1);
          for (int w = 0; w < TO; w++) begin
            if (ctl_kind != 0 && s == ctl_step && retry == 0 && w == 0) begin
              hit_valid = 1'b0; start = 1'b0;
              if (ctl_kind == 1) begin
                abort = 1'b1;
                tick();
                abort = 1'b0; exp_led = 0; exp_busy = 0; exp_done = 0;
              end else begin
                rst = 1'b1;
                tick();
                rst = 1'b0; reset_exp();
              end
              return;
            end
            hv = (kind != 3) && (w == k);
            hit_valid = hv;
            if (hv) {hit_octave, hit_note, hit_length} = {ho, hn, hl};
            else {hit_octave, hit_note, hit_length} = 9'($urandom_range(0, 511));
            start = !hv && ($urandom_range(0, 7) == 0);
            if (w == 0) led_log.push_back(int'(note_led));
            tick();
            if (hv) break;
          end
          hit_valid = 1'b0; start = 1'b0; exp_led = 0;
          exp_correct = mt; exp_wrong = !mt;
          tick();
          exp_correct = 0; exp_wrong = 0;
          if (mt) begin
            m_score   = sat(m_score + ((retry == 0) ? 2 : 1), 255);
            m_score_s = sat(m_score_s + ((retry == 0) ? 2 : 1), 3);
            fin = 1'b1;
          end else if (retry == MAXR - 1) begin
            m_miss = sat(m_miss + 1, 255); m_miss_s = sat(m_miss_s + 1, 3);
            fin = 1'b1;
          end else begin
            retry++;
          end
        end
      end
      tick();
    end
    exp_busy = 0; exp_done = 1;
  endtask

  initial begin
    int c_c, c_w, c_p, c_l, len;
    rst = 1'b1; start = 1'b0; abort = 1'b0; strict = 1'b0; demo_en = 1'b0; song_len = 7'd0;
    hit_valid = 1'b0; hit_octave = 3'd0; hit_note = 3'd0; hit_length = 3'd0; sound_done = 1'b0;
    for (int i = 0; i < 64; i++) set_step(i, 0, 0, 0);
    reset_exp();
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;
    tick();
    chk("rst_score", score, 0); chk("rst_led", note_led, 0); chk("rst_busy", busy, 0);

    // Smoke
    set_step(0, 4, 1, 2); set_step(1, 4, 3, 2); set_step(2, 4, 5, 2);
    plan = '{0, 0, 0}; led_log.delete(); c_c = cnt_correct;
    run_session(3, 1'b0, 1'b0, 0, 0);
    chk("smoke_score", score, 6); chk("smoke_misses", misses, 0); chk("smoke_done", done, 1);
    chk("smoke_correct_pulses", cnt_correct - c_c, 3);
    chk("smoke_led0", led_log[0], 1); chk("smoke_led1", led_log[1], 4); chk("smoke_led2", led_log[2], 16);
    chk("sat_score", s_score, 3);

    // Retry then miss
    set_step(0, 4, 1, 2); set_step(1, 4, 3, 2);
    plan = '{1, 0, 1, 1, 1}; c_w = cnt_wrong;
    run_session(2, 1'b0, 1'b0, 0, 0);
    chk("retry_score", score, 1); chk("retry_misses", misses, 1);
    chk("retry_wrong_pulses", cnt_wrong - c_w, 4); chk("retry_addr", step_addr, 1);

    // Strict versus relaxed length check
    set_step(0, 4, 5, 2);
    plan = '{2, 0}; c_w = cnt_wrong; c_c = cnt_correct;
    run_session(1, 1'b1, 1'b0, 0, 0);
    chk("strict_wrong", cnt_wrong - c_w, 1); chk("strict_score", score, 1);
    plan = '{2}; c_c = cnt_correct;
    run_session(1, 1'b0, 1'b0, 0, 0);
    chk("relaxed_correct", cnt_correct - c_c, 1); chk("relaxed_score", score, 2);

    // Timeouts with demo
    plan = '{3, 3, 3}; c_w = cnt_wrong; c_p = cnt_play; c_l = cnt_led;
    run_session(1, 1'b0, 1'b1, 0, 0);
    chk("to_wrong", cnt_wrong - c_w, 3); chk("to_play", cnt_play - c_p, 3);
    chk("to_wait_cycles", cnt_led - c_l, 3 * TO); chk("to_misses", misses, 1);

    // Empty song, rest step, hit coinciding with timeout
    run_session(0, 1'b0, 1'b0, 0, 0);
    chk("empty_done", done, 1); chk("empty_score", score, 0);
    set_step(0, 4, 0, 2); set_step(1, 4, 2, 2);
    plan = '{0}; led_log.delete();
    run_session(2, 1'b0, 1'b0, 0, 0);
    chk("rest_led_count", led_log.size(), 1); chk("rest_led", led_log[0], 2); chk("rest_score", score, 2);
    set_step(0, 4, 5, 2);
    plan = '{4};
    run_session(1, 1'b1, 1'b0, 0, 0);
    chk("coincide_score", score, 2);

    // Abort and mid-song reset
    set_step(0, 4, 1, 2); set_step(1, 4, 3, 2); set_step(2, 4, 5, 2);
    plan = '{0, 0};
    run_session(3, 1'b0, 1'b0, 1, 1);
    chk("abort_busy", busy, 0); chk("abort_score", score, 2);
    plan = '{0, 0};
    run_session(3, 1'b0, 1'b1, 1, 2);
    chk("rst_mid_score", score, 0); chk("rst_mid_goal", goal_note, 0);

    // Random sessions
    for (int n = 0; n < 14; n++) begin
      int r;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        set_step(i, $urandom_range(0, 7), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(0, 7));
      plan.delete();
      r = $urandom_range(0, 9);
      run_session(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, len - 1),
                  (r == 0) ? 1 : ((r == 1) ? 2 : 0));
      tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
